// File: rtl/elevador_pkg.sv
// elevador_pkg: door-state encoding and default tick counts shared by the elevator blocks
package elevador_pkg;
    typedef enum logic [1:0] {
        CERRADA  = 2'd0,
        ABRIENDO = 2'd1,
        ABIERTA  = 2'd2,
        CERRANDO = 2'd3
    } estado_t;
    localparam int T_ABRIR   = 3;
    localparam int T_ABIERTA = 10;
    localparam int T_CERRAR  = 3;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: one-cycle tick on each rising edge of the slow divider square wave
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic tick
);
    logic d_q;
    always_ff @(posedge clk)
        if (rst) d_q <= 1'b1;
        else     d_q <= d;
    assign tick = d & ~d_q;
endmodule

// File: rtl/temporizador_puerta.sv
// temporizador_puerta: times door open/hold/close phases in ticks of the 1 Hz divider output
module temporizador_puerta #(
    parameter int T_ABRIR   = elevador_pkg::T_ABRIR,
    parameter int T_ABIERTA = elevador_pkg::T_ABIERTA,
    parameter int T_CERRAR  = elevador_pkg::T_CERRAR,
    parameter int CW        = 8
) (
    input  logic C_100Mhz,
    input  logic Reset,
    input  logic C_1Hz,
    input  logic abrir,
    input  logic cerrar_btn,
    input  logic obstaculo,
    output logic motor_abrir,
    output logic motor_cerrar,
    output logic puerta_cerrada,
    output logic listo
);
    import elevador_pkg::*;
    estado_t est, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic tick, listo_n;
    detector_flanco u_det (
        .clk (C_100Mhz),
        .rst (Reset),
        .d   (C_1Hz),
        .tick(tick)
    );
    always_comb begin
        nxt     = est;
        cnt_n   = tick ? cnt + 1'b1 : cnt;
        listo_n = 1'b0;
        case (est)
            CERRADA: begin
                cnt_n = '0;
                nxt   = abrir ? ABRIENDO : CERRADA;
            end
            ABRIENDO: nxt = (tick && cnt == CW'(T_ABRIR - 1)) ? ABIERTA : ABRIENDO;
            ABIERTA:
                if (obstaculo || abrir) cnt_n = '0;
                else if (cerrar_btn || (tick && cnt == CW'(T_ABIERTA - 1))) nxt = CERRANDO;
            CERRANDO:
                if (obstaculo || abrir) nxt = ABRIENDO;
                else if (tick && cnt == CW'(T_CERRAR - 1)) begin
                    nxt     = CERRADA;
                    listo_n = 1'b1;
                end
            default: nxt = CERRADA;
        endcase
        if (nxt != est) cnt_n = '0;
    end
    always_ff @(posedge C_100Mhz)
        if (Reset) begin
            est            <= CERRADA;
            cnt            <= '0;
            motor_abrir    <= 1'b0;
            motor_cerrar   <= 1'b0;
            puerta_cerrada <= 1'b1;
            listo          <= 1'b0;
        end else begin
            est            <= nxt;
            cnt            <= cnt_n;
            motor_abrir    <= nxt == ABRIENDO;
            motor_cerrar   <= nxt == CERRANDO;
            puerta_cerrada <= nxt == CERRADA;
            listo          <= listo_n;
        end
endmodule

// File: tb/tb_temporizador_puerta.sv
// tb_temporizador_puerta: tick-by-tick directed vectors for the door sequencer
module tb_temporizador_puerta;
    logic C_100Mhz = 1'b0, Reset = 1'b1, C_1Hz = 1'b1;
    logic abrir = 1'b0, cerrar_btn = 1'b0, obstaculo = 1'b0;
    logic motor_abrir, motor_cerrar, puerta_cerrada, listo;
    int errors = 0, checks = 0, ph = 4, both_cnt = 0, listo_cnt = 0;
    typedef struct packed {
        logic [2:0] in;
        logic [3:0] out;
    } vec_t;
    vec_t vecs[48];
    always #5 C_100Mhz = ~C_100Mhz;
    temporizador_puerta #(.T_ABRIR(2), .T_ABIERTA(3), .T_CERRAR(2), .CW(8)) dut (
        .C_100Mhz      (C_100Mhz),
        .Reset         (Reset),
        .C_1Hz         (C_1Hz),
        .abrir         (abrir),
        .cerrar_btn    (cerrar_btn),
        .obstaculo     (obstaculo),
        .motor_abrir   (motor_abrir),
        .motor_cerrar  (motor_cerrar),
        .puerta_cerrada(puerta_cerrada),
        .listo         (listo)
    );
    always @(negedge C_100Mhz) begin
        if (motor_abrir && motor_cerrar) both_cnt++;
        if (listo) listo_cnt++;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge C_100Mhz);
        #1;
        ph = (ph + 1) % 8;
        C_1Hz = ph >= 4;
    endtask
    task automatic tick_step(input logic [2:0] in);
        while (ph != 4) step();
        {abrir, cerrar_btn, obstaculo} = in;
        step();
        {abrir, cerrar_btn, obstaculo} = 3'b000;
    endtask
    function automatic logic [3:0] outs();
        return {motor_abrir, motor_cerrar, puerta_cerrada, listo};
    endfunction
    initial begin
        vecs[0]  = 7'b100_1000; vecs[1]  = 7'b000_1000; vecs[2]  = 7'b000_0000; vecs[3]  = 7'b000_0000;
        vecs[4]  = 7'b000_0000; vecs[5]  = 7'b000_0100; vecs[6]  = 7'b000_0100; vecs[7]  = 7'b000_0011;
        vecs[8]  = 7'b100_1000; vecs[9]  = 7'b000_1000; vecs[10] = 7'b000_0000; vecs[11] = 7'b000_0000;
        vecs[12] = 7'b000_0000; vecs[13] = 7'b000_0100; vecs[14] = 7'b001_1000; vecs[15] = 7'b000_1000;
        vecs[16] = 7'b000_0000; vecs[17] = 7'b000_0000; vecs[18] = 7'b000_0000; vecs[19] = 7'b000_0100;
        vecs[20] = 7'b000_0100; vecs[21] = 7'b000_0011; vecs[22] = 7'b100_1000; vecs[23] = 7'b000_1000;
        vecs[24] = 7'b000_0000; vecs[25] = 7'b010_0100; vecs[26] = 7'b000_0100; vecs[27] = 7'b000_0011;
        vecs[28] = 7'b100_1000; vecs[29] = 7'b000_1000; vecs[30] = 7'b000_0000; vecs[31] = 7'b011_0000;
        vecs[32] = 7'b000_0000; vecs[33] = 7'b000_0000; vecs[34] = 7'b000_0100; vecs[35] = 7'b000_0100;
        vecs[36] = 7'b000_0011; vecs[37] = 7'b100_1000; vecs[38] = 7'b000_1000; vecs[39] = 7'b000_0000;
        vecs[40] = 7'b000_0000; vecs[41] = 7'b000_0000; vecs[42] = 7'b100_0000; vecs[43] = 7'b000_0000;
        vecs[44] = 7'b000_0000; vecs[45] = 7'b000_0100; vecs[46] = 7'b000_0100; vecs[47] = 7'b000_0011;
        repeat (10) @(posedge C_100Mhz);
        #1;
        Reset = 1'b0;
        check("tick_at_release", 32'(dut.tick), 32'd0);
        check("reset_outputs", 32'(outs()), 32'b0010);
        step();
        check("no_spurious_tick", 32'(dut.tick), 32'd0);
        check("idle_after_release", 32'(outs()), 32'b0010);
        for (int i = 0; i < 48; i++) begin
            tick_step(vecs[i].in);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].out));
        end
        step();
        check("listo_one_cycle", 32'(outs()), 32'b0010);
        tick_step(3'b100);
        check("opening_before_reset", 32'(outs()), 32'b1000);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("reset_mid_abriendo", 32'(outs()), 32'b0010);
        tick_step(3'b000);
        check("closed_after_reset", 32'(outs()), 32'b0010);
        check("listo_pulses", 32'(listo_cnt), 32'd5);
        check("both_motors_cycles", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/temporizador_puerta.md
Name: temporizador_puerta

Overview:
- Elevator door sequencer that sits directly downstream of the 100 MHz to 1 Hz frequency divider.
- It consumes the slow square wave, turns each rising edge into a one-cycle "tick", and times the door motor phases in ticks: opening, held open (10 s maximum), and closing.
- The main elevator FSM sends it open requests and waits on its closed/done status before moving the car.

Parameters:
- T_ABRIR, 3, ticks the open motor runs (door travel time to fully open); must be >= 1
- T_ABIERTA, 10, ticks the door stays open before auto-close (the 10 s maximum); must be >= 1
- T_CERRAR, 3, ticks the close motor runs; must be >= 1
- CW, 8, tick-counter width; must hold max(T_*)

Ports:
- C_100Mhz  input  1  system clock, 100 MHz
- Reset  input  1  synchronous, active-high reset
- C_1Hz  input  1  slow square wave from the divider, registered in the C_100Mhz domain
- abrir  input  1  level/pulse open request from the main FSM
- cerrar_btn  input  1  "close door" button, already debounced
- obstaculo  input  1  door obstruction sensor, high = blocked
- motor_abrir  output  1  drive door motor open
- motor_cerrar  output  1  drive door motor closed
- puerta_cerrada  output  1  high while the door is fully closed
- listo  output  1  one-cycle pulse when a full open/close cycle completes

Behaviour:
- Interface: one clock, C_100Mhz. Reset is synchronous and active-high: sampled on the C_100Mhz rising edge, no asynchronous path.
- Tick generation:
  - c1hz_q <= C_1Hz every cycle.
  - tick = C_1Hz & ~c1hz_q, high for exactly one cycle per rising edge of C_1Hz.
  - c1hz_q resets to 1, so a high C_1Hz at reset release produces no spurious tick.
- Reset values: state=CERRADA, cnt=0, motor_abrir=0, motor_cerrar=0, puerta_cerrada=1, listo=0.
- All outputs are registered, decoded from the next state, so each output changes in the same cycle as the state register.
- motor_abrir and motor_cerrar are never high together.
- cnt is cleared on every state entry and increments on tick only.
- State CERRADA:
  - outputs: puerta_cerrada=1, motors off.
  - abrir=1 -> ABRIENDO.
  - cerrar_btn and obstaculo are ignored.
- State ABRIENDO:
  - outputs: motor_abrir=1.
  - On a tick with cnt==T_ABRIR-1 -> ABIERTA.
  - abrir, cerrar_btn and obstaculo are ignored (the door is already opening).
- State ABIERTA:
  - outputs: motors off.
  - Priority order: obstaculo=1 or abrir=1 -> cnt cleared, stay in ABIERTA (hold restarts).
  - Otherwise cerrar_btn=1 -> CERRANDO.
  - Otherwise a tick with cnt==T_ABIERTA-1 -> CERRANDO.
- State CERRANDO:
  - outputs: motor_cerrar=1.
  - Priority order: obstaculo=1 or abrir=1 -> ABRIENDO next cycle (reopen); cnt restarts at 0 (full T_ABRIR travel, deliberate conservative choice).
  - Otherwise a tick with cnt==T_CERRAR-1 -> CERRADA, and listo=1 for that one cycle.
- Simultaneous events: the priorities above apply within the same cycle.
  - A tick coinciding with a higher-priority event is consumed by that event; it is not counted.
  - In ABIERTA, cerrar_btn together with obstaculo stays open.
- Timing tolerance: the first tick after state entry counts as 1, so each phase lasts between (T-1) and T tick periods. The bench checks tick counts, not absolute time.
- Reset mid-operation: motors drop the next cycle and the state returns to CERRADA with puerta_cerrada=1. listo is not pulsed.
- Counter: cnt never exceeds T_*-1; no wrap can occur.

Decomposition:
- Shared package elevador_pkg holds:
  - state encoding localparams: CERRADA=2'd0, ABRIENDO=2'd1, ABIERTA=2'd2, CERRANDO=2'd3
  - the default tick constants T_ABRIR, T_ABIERTA, T_CERRAR
- One natural sub-module: detector_flanco, which does the rising-edge detect of C_1Hz into tick (reset value 1 as above).
- The FSM and counter stay in temporizador_puerta.

Test Plan:
- All scenarios use T_ABRIR=2, T_ABIERTA=3, T_CERRAR=2, with C_1Hz toggling every 4 clocks (one tick per 8 clocks).
1. Reset with C_1Hz=1 held for 10 cycles, then release -> no tick; puerta_cerrada=1, motors 0, listo=0.
2. Single abrir pulse -> motor_abrir for 2 ticks, then idle for 3 ticks, then motor_cerrar for 2 ticks, then puerta_cerrada=1 with exactly one listo pulse. No cycle ever has both motors on.
3. obstaculo asserted at tick 1 of CERRANDO -> next cycle motor_abrir=1, motor_cerrar=0; full 2-tick reopen, then a fresh 3-tick hold.
4. cerrar_btn asserted at tick 1 of ABIERTA -> CERRANDO next cycle. Repeat with obstaculo=1 at the same time -> stays ABIERTA with cnt cleared.
5. abrir asserted on the same cycle as the final ABIERTA tick -> hold restarts; door closes 3 ticks later, not immediately.
6. Reset pulsed mid-ABRIENDO -> motor_abrir=0 next cycle, state CERRADA, listo stays 0.
